// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply
// and restoring divide on operand magnitudes, with the signs applied in a single FIX cycle.
module muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    mag_b_q;
    logic           neg_res_q;
    logic           neg_rem_q;
    logic [63:0]    acc_q, acc_d;
    logic [31:0]    hi_q, lo_q;
    logic           busy_q, done_q;

    logic           signed_op;
    logic [31:0]    mag_a, mag_b;
    logic           is_div;
    logic [32:0]    mul_sum;
    logic [32:0]    div_trial;
    logic [63:0]    prod_fix;
    logic [31:0]    quot_fix, rem_fix;
    logic [63:0]    hilo_fix;

    // Operand magnitudes; only even op codes (mult/div/madd/msub) are signed.
    always_comb begin
        signed_op = ~op[0];
        mag_a     = (signed_op && A[31]) ? (~A + 32'd1) : A;
        mag_b     = (signed_op && B[31]) ? (~B + 32'd1) : B;
    end

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        is_div    = (op_q[2:1] == 2'b01);
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
        div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, mag_b_q};
        acc_d     = {mul_sum, acc_q[31:1]};
        if (is_div) begin
            if (!div_trial[32]) begin
                acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_d = {acc_q[62:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        hilo_fix = prod_fix;
        case (op_q)
            3'b100, 3'b101: hilo_fix = {hi_q, lo_q} + prod_fix;
            3'b110, 3'b111: hilo_fix = {hi_q, lo_q} - prod_fix;
            3'b010, 3'b011: begin
                // Divide by zero returns the untouched dividend bits as remainder.
                if (mag_b_q == 32'd0) begin
                    hilo_fix = {a_q, 32'hFFFF_FFFF};
                end else begin
                    hilo_fix = {rem_fix, quot_fix};
                end
            end
            default: hilo_fix = prod_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            mag_b_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel) begin
                        if (!op[3]) begin
                            op_q      <= op[2:0];
                            a_q       <= A;
                            mag_b_q   <= mag_b;
                            neg_res_q <= signed_op & (A[31] ^ B[31]);
                            neg_rem_q <= signed_op & A[31];
                            acc_q     <= {32'd0, mag_a};
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_CALC;
                        end else if (op == 4'b1000) begin
                            hi_q <= A;
                        end else if (op == 4'b1001) begin
                            lo_q <= A;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        {hi_q, lo_q} <= hilo_fix;
                        done_q       <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written control sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi_in, lo_in, exp_hi, exp_lo;
    } vec_t;
    vec_t vecs[12];

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        logic [63:0] sp, up;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        sp = 64'(longint'(sa) * longint'(sb));
        up = {32'd0, a} * {32'd0, b};
        case (o)
            4'd0: return sp;
            4'd1: return up;
            4'd4: return hl + sp;
            4'd5: return hl + up;
            4'd6: return hl - sp;
            4'd7: return hl - up;
            4'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return hl;
        endcase
    endfunction

    task automatic mt(input logic [3:0] o, input logic [31:0] d);
        start = 1'b1; op = o; A = d;
        tick();
        start = 1'b0;
        check("mt_busy", busy, 0);
        check("mt_done", done, 0);
    endtask

    // Accepts an op at the next edge, then scrambles A/B to catch re-sampling.
    task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0;
        A = $urandom; B = $urandom;
        check("start_busy", busy, 1);
    endtask

    task automatic wait_done(input int n0);
        int n = n0;
        logic early = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (!busy) break;
            if (done) early = 1'b1;
            n++;
        end
        check("busy_cycles", n, 33);
        check("done_during_busy", early, 0);
        check("done_pulse", done, 1);
    endtask

    task automatic done_clears();
        tick();
        check("done_clear", done, 0);
    endtask

    initial begin
        logic [63:0] m, e;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic        saw_done;

        vecs[0]  = '{4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{4'h0, 32'hFFFFFFFD, 32'h7,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{4'h2, 32'hFFFFFFF9, 32'h2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'h3, 32'h7,        32'h0,        32'h0, 32'h0, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{4'h5, 32'h1,        32'h1,        32'h0, 32'hFFFFFFFF, 32'h1, 32'h0};
        vecs[5]  = '{4'h6, 32'h2,        32'h1,        32'h1, 32'h0, 32'h0, 32'hFFFFFFFE};
        vecs[6]  = '{4'h2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h0, 32'h80000000};
        vecs[7]  = '{4'h2, 32'h80000000, 32'h0,        32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF};
        vecs[8]  = '{4'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h5, 32'h0, 32'h6};
        vecs[9]  = '{4'h7, 32'h2,        32'h3,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[10] = '{4'h3, 32'hFFFFFFFF, 32'h10,       32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{4'h2, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'h0; A = '0; B = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        foreach (vecs[i]) begin
            mt(4'h8, vecs[i].hi_in);
            mt(4'h9, vecs[i].lo_in);
            check("preload_hi", HI, vecs[i].hi_in);
            check("preload_lo", LO, vecs[i].lo_in);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1);
            check("vec_hi", HI, vecs[i].exp_hi);
            check("vec_lo", LO, vecs[i].exp_lo);
            done_clears();
        end

        // Back-to-back: divu issued in the done cycle of the previous divide.
        start_op(4'h2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1);
        check("b2b_first_lo", LO, 32'h80000000);
        start = 1'b1; op = 4'h3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done(1);
        check("b2b_hi", HI, 32'd2);
        check("b2b_lo", LO, 32'd14);
        done_clears();

        // Start reasserted while busy must be ignored.
        start_op(4'h0, 32'd3, 32'd5);
        repeat (4) tick();
        start = 1'b1; op = 4'h1; A = 32'd7; B = 32'd9;
        tick();
        start = 1'b0;
        wait_done(6);
        check("restart_hi", HI, 32'd0);
        check("restart_lo", LO, 32'd15);
        done_clears();

        // Cancel during CALC.
        mt(4'h8, 32'h11);
        mt(4'h9, 32'h22);
        start_op(4'h2, 32'd100, 32'd3);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("cancel_no_done", saw_done, 0);
        check("cancel_hi", HI, 32'h11);
        check("cancel_lo", LO, 32'h22);

        // Cancel on the FIX cycle.
        start_op(4'h1, 32'd5, 32'd5);
        repeat (32) tick();
        check("fix_busy", busy, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("fixcancel_busy", busy, 0);
        check("fixcancel_done", done, 0);
        check("fixcancel_hi", HI, 32'h11);
        check("fixcancel_lo", LO, 32'h22);

        // Reset mid-operation.
        start_op(4'h1, 32'hFFFF, 32'hFFFF);
        repeat (19) tick();
        rst = 1'b1; cancel = 1'b1;
        tick();
        rst = 1'b0; cancel = 1'b0;
        check("midrst_hi", HI, 0);
        check("midrst_lo", LO, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);

        // Cancel beats start in IDLE; invalid op is a no-op.
        mt(4'h9, 32'h33);
        check("mtlo_lo", LO, 32'h33);
        start = 1'b1; cancel = 1'b1; op = 4'h9; A = 32'h44;
        tick();
        op = 4'h1; A = 32'd2; B = 32'd2;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_mtlo_lo", LO, 32'h33);
        check("cancel_start_busy", busy, 0);
        start = 1'b1; op = 4'hA; A = 32'h55;
        tick();
        start = 1'b0;
        check("invalid_busy", busy, 0);
        check("invalid_hi", HI, 32'h0);
        check("invalid_lo", LO, 32'h33);
        done_clears();

        // Random operations against the reference model.
        m = {32'h0, 32'h33};
        for (int k = 0; k < 40; k++) begin
            o = 4'($urandom_range(0, 9));
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if (o == 4'h8) begin
                m[63:32] = a;
                mt(o, a);
            end else if (o == 4'h9) begin
                m[31:0] = a;
                mt(o, a);
            end else begin
                e = model(o, a, b, m);
                m = e;
                exp_q.push_back(e[63:32]);
                exp_q.push_back(e[31:0]);
                start_op(o, a, b);
                wait_done(1);
                check("rand_hi", HI, exp_q.pop_front());
                check("rand_lo", LO, exp_q.pop_front());
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        check("final_hi", HI, m[63:32]);
        check("final_lo", LO, m[31:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
